// File: rtl/traffic_ctrl_param_pkg.sv
// traffic_pkg: shared types and constants for the parametrised highway /
// farm-road light controller.
//   state_t  - controller phases; the all-red members ARF/ARH are always
//              declared so debug tooling sees one encoding in every build.
//   HWY/FARM - lamp vector bit for each road (bit1 = highway, bit0 = farm).
//   ALL/NONE - every lamp of a colour on / off.
//   max_of   - integer maximum, used for elaborating widths.
//   calc_tw  - bits needed to hold a seconds count of 0..max_dur.
package traffic_pkg;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        FG  = 3'd2,
        FY  = 3'd3,
        ARF = 3'd4,
        ARH = 3'd5
    } state_t;

    localparam logic [1:0] HWY  = 2'b10;
    localparam logic [1:0] FARM = 2'b01;
    localparam logic [1:0] ALL  = 2'b11;
    localparam logic [1:0] NONE = 2'b00;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int calc_tw(input int max_dur);
        return (max_dur < 1) ? 1 : $clog2(max_dur + 1);
    endfunction

endpackage

// File: rtl/traffic_ctrl_param_if.sv
// traffic_ctrl_param_if: controller-facing signal bundle.
//   has_car    farm-road sensor level (environment -> controller)
//   red        lamp vector, bit1 = highway, bit0 = farm
//   yellow     same bit mapping as red
//   green      same bit mapping as red
//   remaining  seconds left in the current phase, TW bits
//   tick       one-cycle pulse per second
//   state_dbg  current controller phase, for observation only
// Modports: ctrl (the controller drives lamps/timing), env (the lab top or
// bench drives the sensor).
// Handshake: there is no valid/ready pair on this bundle. has_car is a plain
// level that the controller samples only in cycles where tick is high; every
// output is a registered-state decode and is valid in every cycle.
interface traffic_ctrl_param_if
    import traffic_pkg::*;
#(
    parameter int TW = 3
);
    logic          has_car;
    logic [1:0]    red;
    logic [1:0]    yellow;
    logic [1:0]    green;
    logic [TW-1:0] remaining;
    logic          tick;
    state_t        state_dbg;

    modport ctrl (
        input  has_car,
        output red, yellow, green, remaining, tick, state_dbg
    );

    modport env (
        output has_car,
        input  red, yellow, green, remaining, tick, state_dbg
    );
endinterface

// File: rtl/traffic_ctrl_param_sec_tick.sv
// sec_tick: N-cycle prescaler producing a one-cycle tick.
//   clk    system clock
//   reset  synchronous, active-high; clears the count to 0
//   tick   high in the cycle the count equals N-1
// The count runs 0..N-1 and wraps. With N = 1 the count is pinned at 0 and
// tick is high in every cycle, including the first cycle after reset.
module sec_tick #(
    parameter int N = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: parametrised highway / farm-road light controller.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    traffic_ctrl_param_if.ctrl: has_car in; red/yellow/green lamps,
//          remaining seconds, per-second tick and state_dbg out
// Optional build macro ALL_RED_CLEARANCE_EN inserts all-red clearance phases
// ARF (HY -> ARF -> FG) and ARH (FY -> ARH -> HG), each ALLRED_S seconds.
// State and remaining change only on tick cycles; lamps are a Moore decode
// of the state register.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int N        = 2_000_000,
    parameter int HG_MIN_S = 4,
    parameter int HY_S     = 1,
    parameter int FG_MAX_S = 4,
    parameter int FY_S     = 1,
    parameter int ALLRED_S = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_ctrl_param_if.ctrl   bus
);
    // ALLRED_S is folded into the width in every build so the remaining
    // port keeps one width whether or not clearance is compiled in.
    localparam int MAX_DUR = max_of(max_of(max_of(HG_MIN_S, HY_S),
                                           max_of(FG_MAX_S, FY_S)), ALLRED_S);
    localparam int TW      = calc_tw(MAX_DUR);

    localparam logic [TW-1:0] HG_LD = TW'(HG_MIN_S);
    localparam logic [TW-1:0] HY_LD = TW'(HY_S);
    localparam logic [TW-1:0] FG_LD = TW'(FG_MAX_S);
    localparam logic [TW-1:0] FY_LD = TW'(FY_S);
    localparam logic [TW-1:0] AR_LD = TW'(ALLRED_S);
    localparam logic [TW-1:0] ONE   = TW'(1);

    logic          tick;
    state_t        state_q, state_d;
    logic [TW-1:0] rem_q, rem_d;
    logic          last_sec;
    logic [TW-1:0] rem_dec;
    logic [1:0]    red_l, yellow_l, green_l;

    sec_tick #(.N(N)) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HG;
            rem_q   <= HG_LD;
        end else if (tick) begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // "<= 1" rather than "== 1" so a held HG at 0 still counts as expired
    // and the decrement path can never wrap below zero.
    assign last_sec = (rem_q <= ONE);
    assign rem_dec  = rem_q - ONE;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            HG: begin
                if (!last_sec) begin
                    rem_d = rem_dec;
                end else if (bus.has_car) begin
                    state_d = HY;
                    rem_d   = HY_LD;
                end else begin
                    rem_d = '0;
                end
            end
            HY: begin
                if (!last_sec) begin
                    rem_d = rem_dec;
                end else begin
`ifdef ALL_RED_CLEARANCE_EN
                    state_d = ARF;
                    rem_d   = AR_LD;
`else
                    state_d = FG;
                    rem_d   = FG_LD;
`endif
                end
            end
            FG: begin
                // An empty farm road ends green early, ahead of the timer.
                if (!bus.has_car || last_sec) begin
                    state_d = FY;
                    rem_d   = FY_LD;
                end else begin
                    rem_d = rem_dec;
                end
            end
            FY: begin
                if (!last_sec) begin
                    rem_d = rem_dec;
                end else begin
`ifdef ALL_RED_CLEARANCE_EN
                    state_d = ARH;
                    rem_d   = AR_LD;
`else
                    state_d = HG;
                    rem_d   = HG_LD;
`endif
                end
            end
`ifdef ALL_RED_CLEARANCE_EN
            // Clearance ignores the sensor: FG follows ARF unconditionally.
            ARF: begin
                if (!last_sec) begin
                    rem_d = rem_dec;
                end else begin
                    state_d = FG;
                    rem_d   = FG_LD;
                end
            end
            ARH: begin
                if (!last_sec) begin
                    rem_d = rem_dec;
                end else begin
                    state_d = HG;
                    rem_d   = HG_LD;
                end
            end
`endif
            default: begin
                // Unreachable encodings recover to highway green.
                state_d = HG;
                rem_d   = HG_LD;
            end
        endcase
    end

    always_comb begin
        red_l    = ALL;
        yellow_l = NONE;
        green_l  = NONE;
        case (state_q)
            HG: begin
                red_l   = FARM;
                green_l = HWY;
            end
            HY: begin
                red_l    = FARM;
                yellow_l = HWY;
            end
            FG: begin
                red_l   = HWY;
                green_l = FARM;
            end
            FY: begin
                red_l    = HWY;
                yellow_l = FARM;
            end
            default: begin
                red_l = ALL;
            end
        endcase
    end

    assign bus.red       = red_l;
    assign bus.yellow    = yellow_l;
    assign bus.green     = green_l;
    assign bus.remaining = rem_q;
    assign bus.tick      = tick;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Self-checking bench for traffic_ctrl_param (N=4, HG=3, HY=1, FG=3, FY=1).
// Reference model: phase route table plus per-phase durations, stepped once
// per second; outputs compared every cycle plus directed checks.
module tb_traffic_ctrl_param;
    import traffic_pkg::*;

    localparam int N        = 4;
    localparam int HG_MIN_S = 3;
    localparam int HY_S     = 1;
    localparam int FG_MAX_S = 3;
    localparam int FY_S     = 1;
    localparam int ALLRED_S = 1;
    localparam int TW = calc_tw(max_of(max_of(max_of(HG_MIN_S, HY_S),
                                              max_of(FG_MAX_S, FY_S)), ALLRED_S));
`ifdef ALL_RED_CLEARANCE_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    // Full cycle with the sensor held high, in clocks.
    localparam int PERIOD = N * (HG_MIN_S + HY_S + FG_MAX_S + FY_S + (FEAT ? 2 * ALLRED_S : 0));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic has_car = 1'b0;
    always #5 clk = ~clk;

    traffic_ctrl_param_if #(.TW(TW)) bus ();
    assign bus.has_car = has_car;

    traffic_ctrl_param #(
        .N(N), .HG_MIN_S(HG_MIN_S), .HY_S(HY_S),
        .FG_MAX_S(FG_MAX_S), .FY_S(FY_S), .ALLRED_S(ALLRED_S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_q[$];          // expected HG-entry spacing, one per gap
    int          hg_entry_q[$];     // observed cycles at which HG was entered
    state_t trk_prev;
    int     run_len;
    int     fg_last_len;

    // ---------------- reference model ----------------
    state_t m_state;
    int     m_rem;
    int     m_pre;

    function automatic int dur(input state_t s);
        case (s)
            HG:      return HG_MIN_S;
            HY:      return HY_S;
            FG:      return FG_MAX_S;
            FY:      return FY_S;
            default: return ALLRED_S;
        endcase
    endfunction

    function automatic state_t route_next(input state_t s);
        case (s)
            HG:      return HY;
            HY:      return FEAT ? ARF : FG;
            ARF:     return FG;
            FG:      return FY;
            FY:      return FEAT ? ARH : HG;
            default: return HG;
        endcase
    endfunction

    task automatic m_enter(input state_t s);
        m_state = route_next(s);
        m_rem   = dur(m_state);
    endtask

    task automatic m_second();
        case (m_state)
            HG: begin
                if (m_rem > 1)    m_rem = m_rem - 1;
                else if (has_car) m_enter(HG);
                else              m_rem = 0;
            end
            FG: begin
                if (!has_car || m_rem == 1) m_enter(FG);
                else                        m_rem = m_rem - 1;
            end
            default: begin
                if (m_rem == 1) m_enter(m_state);
                else            m_rem = m_rem - 1;
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s", tag);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] er, ey, eg;
        case (m_state)
            HG:      begin er = 2'b01; ey = 2'b00; eg = 2'b10; end
            HY:      begin er = 2'b01; ey = 2'b10; eg = 2'b00; end
            FG:      begin er = 2'b10; ey = 2'b00; eg = 2'b01; end
            FY:      begin er = 2'b10; ey = 2'b01; eg = 2'b00; end
            default: begin er = 2'b11; ey = 2'b00; eg = 2'b00; end
        endcase
        chk("tick",      32'(bus.tick),      32'(m_pre == N - 1));
        chk("state",     32'(bus.state_dbg), 32'(m_state));
        chk("remaining", 32'(bus.remaining), 32'(m_rem));
        chk("red",       32'(bus.red),       32'(er));
        chk("yellow",    32'(bus.yellow),    32'(ey));
        chk("green",     32'(bus.green),     32'(eg));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: check at the falling edge, step the model, return #1 after
    // the rising edge where the caller may change inputs.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (bus.state_dbg != trk_prev) begin
            if (trk_prev == FG) fg_last_len = run_len;
            if (bus.state_dbg == HG) hg_entry_q.push_back(cyc);
            trk_prev = bus.state_dbg;
            run_len  = 1;
        end else begin
            run_len++;
        end
        if (m_pre == N - 1) begin
            m_pre = 0;
            m_second();
        end else begin
            m_pre = m_pre + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
        reset       = 1'b0;
        m_state     = HG;
        m_rem       = HG_MIN_S;
        m_pre       = 0;
        trk_prev    = HG;
        run_len     = 0;
        fg_last_len = 0;
        hg_entry_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // 1: reset, no cars: HG counts down 3,2,1,0 and holds.
        has_car = 1'b0;
        do_reset(2);
        chk("rst_state", 32'(bus.state_dbg), 32'(HG));
        chk("rst_rem",   32'(bus.remaining), 32'(HG_MIN_S));
        chk("rst_tick",  32'(bus.tick),      32'd0);
        chk("rst_red",   32'(bus.red),       32'b01);
        chk("rst_green", 32'(bus.green),     32'b10);
        run(24);
        chk("hold_state", 32'(bus.state_dbg), 32'(HG));
        chk("hold_rem",   32'(bus.remaining), 32'd0);

        // 2: sensor held high: steady repeating period.
        has_car = 1'b1;
        hg_entry_q.delete();
        run(3 * PERIOD + 8);
        chk("hg_entries", 32'(hg_entry_q.size() >= 2), 32'd1);
        for (int i = 1; i < hg_entry_q.size(); i++) exp_q.push_back(32'(PERIOD));
        for (int i = 1; i < hg_entry_q.size(); i++) begin
            chk("period", 32'(hg_entry_q[i] - hg_entry_q[i-1]), exp_q.pop_front());
        end

        // 3: farm road empties after the first FG second -> early FY.
        for (int k = 0; k < 4 * PERIOD && m_state != FG; k++) cycle();
        chk("reach_fg", 32'(bus.state_dbg), 32'(FG));
        for (int k = 0; k < 4 * N && !(m_state == FG && m_rem == FG_MAX_S - 1); k++) cycle();
        has_car = 1'b0;
        for (int k = 0; k < 4 * N && m_state != FY; k++) cycle();
        chk("early_fy",     32'(bus.state_dbg), 32'(FY));
        chk("early_fy_rem", 32'(bus.remaining), 32'(FY_S));
        run(1);
        chk("fg_early_len", 32'(fg_last_len), 32'(2 * N));

        // 4: sensor pulse strictly between ticks while HG holds at 0.
        for (int k = 0; k < 4 * PERIOD && !(m_state == HG && m_rem == 0); k++) cycle();
        chk("hold0_state", 32'(bus.state_dbg), 32'(HG));
        for (int k = 0; k < 2 * N && m_pre != 1; k++) cycle();
        has_car = 1'b1;
        run(2);
        has_car = 1'b0;
        run(3 * N);
        chk("pulse_no_hy",  32'(bus.state_dbg), 32'(HG));
        chk("pulse_rem",    32'(bus.remaining), 32'd0);

        // 5: reset pulse in the middle of FG.
        has_car = 1'b1;
        for (int k = 0; k < 4 * PERIOD && m_state != FG; k++) cycle();
        run(N + 1);
        chk("mid_fg", 32'(bus.state_dbg), 32'(FG));
        do_reset(1);
        chk("mr_state", 32'(bus.state_dbg), 32'(HG));
        chk("mr_rem",   32'(bus.remaining), 32'(HG_MIN_S));
        chk("mr_red",   32'(bus.red),       32'b01);
        chk("mr_green", 32'(bus.green),     32'b10);
        chk("mr_tick",  32'(bus.tick),      32'd0);
        run(2 * N + 1);

        // 6: randomised sensor activity against the model.
        for (int i = 0; i < 80; i++) begin
            has_car = 1'($urandom_range(0, 1));
            run($urandom_range(1, 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
